demux_1to2_buffered: RTL

Registered 1-to-2 demultiplexer with a valid/ready handshake on every port. It steers each accepted 32-bit word to output A or output B according to a per-word select bit. It is the distribution-side counterpart of the 2-to-1 selection mux in the floating-point square-root datapath, used where one producer feeds two consumers that may stall independently. Each output owns a one-entry holding register, so a stall on one side never blocks traffic to the other.

---
 rtl/demux_1to2_buffered.sv | 108 ++++++++++
 1 files changed

// File: rtl/demux_1to2_buffered.sv
// rtl/demux_1to2_buffered.sv - registered 1-to-2 valid/ready demux with a one-entry holding register per output
// Optional macro DEMUX_XFER_COUNT_EN adds 16-bit wrapping output-transfer counters countA_o/countB_o.
module demux_1to2_buffered #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  select_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] dataA_o,
    output logic                  validA_o,
    input  logic                  readyA_i,
    output logic [DATA_WIDTH-1:0] dataB_o,
    output logic                  validB_o,
    input  logic                  readyB_i
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [15:0]           countA_o,
    output logic [15:0]           countB_o
`endif
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e                state_a_q, state_a_d;
    state_e                state_b_q, state_b_d;
    logic [DATA_WIDTH-1:0] data_a_q,  data_a_d;
    logic [DATA_WIDTH-1:0] data_b_q,  data_b_d;

    logic in_xfer, in_a, in_b, out_a, out_b;

    // A full channel may still accept when its consumer drains on the same edge.
    always_comb begin
        ready_o = select_i ? (!validB_o | readyB_i) : (!validA_o | readyA_i);
        in_xfer = valid_i & ready_o;
        in_a    = in_xfer & !select_i;
        in_b    = in_xfer &  select_i;
        out_a   = validA_o & readyA_i;
        out_b   = validB_o & readyB_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_a_q <= ST_EMPTY;
            state_b_q <= ST_EMPTY;
            data_a_q  <= '0;
            data_b_q  <= '0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
        end
    end

    always_comb begin
        state_a_d = state_a_q;
        case (state_a_q)
            ST_EMPTY: if (in_a) state_a_d = ST_FULL;
            ST_FULL:  if (out_a && !in_a) state_a_d = ST_EMPTY;
            default:  state_a_d = ST_EMPTY;
        endcase
        data_a_d = in_a ? data_i : data_a_q;
    end

    always_comb begin
        state_b_d = state_b_q;
        case (state_b_q)
            ST_EMPTY: if (in_b) state_b_d = ST_FULL;
            ST_FULL:  if (out_b && !in_b) state_b_d = ST_EMPTY;
            default:  state_b_d = ST_EMPTY;
        endcase
        data_b_d = in_b ? data_i : data_b_q;
    end

    always_comb begin
        validA_o = (state_a_q == ST_FULL);
        validB_o = (state_b_q == ST_FULL);
        dataA_o  = data_a_q;
        dataB_o  = data_b_q;
    end

`ifdef DEMUX_XFER_COUNT_EN
    logic [15:0] count_a_q, count_a_d;
    logic [15:0] count_b_q, count_b_d;

    always_comb begin
        count_a_d = out_a ? count_a_q + 16'd1 : count_a_q;
        count_b_d = out_b ? count_b_q + 16'd1 : count_b_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_a_q <= '0;
            count_b_q <= '0;
        end else begin
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
        end
    end

    assign countA_o = count_a_q;
    assign countB_o = count_b_q;
`endif

endmodule
